// File: rtl/rr_arb8_idx.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb8_idx
// Purpose  : 8-way round-robin arbiter with a registered binary grant index,
//            a done/withdraw release handshake and a hold timeout.
//            Optional grant lock via macro RR_ARB8_LOCK_EN.
// Revision : 1.0  initial release
// ============================================================================
module rr_arb8_idx #(
  parameter int TIMEOUT = 16,
  parameter int CW      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
`ifdef RR_ARB8_LOCK_EN
  input  logic       lock,
`endif
  output logic [2:0] gnt_idx,
  output logic       gnt_vld,
  output logic       tmo
);

  localparam logic [0:0] c_idle  = 1'b0;
  localparam logic [0:0] c_grant = 1'b1;
  localparam int         c_tmo_last = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  logic [0:0]    r_state;
  logic [2:0]    r_ptr;
  logic [CW-1:0] r_cnt;

  logic          w_lock;
  logic          w_cur_req;
  logic          w_tmo_hit;
  logic          w_tmo_rel;
  logic          w_release;
  logic          w_tmo_evt;
  logic          w_hold_sat;
  logic [3:0]    w_idle_pick;
  logic [3:0]    w_next_pick;

  // Returns {found, index} of the first set bit scanning start, start+1, ... mod 8.
  function automatic logic [3:0] f_pick(input logic [7:0] mask, input logic [2:0] start);
    logic [3:0] res;
    logic [2:0] k;
    res = 4'b0;
    for (int i = 7; i >= 0; i--) begin
      k = start + 3'(i);
      if (mask[k]) res = {1'b1, k};
    end
    return res;
  endfunction

`ifdef RR_ARB8_LOCK_EN
  assign w_lock = lock;
`else
  assign w_lock = 1'b0;
`endif

  assign w_cur_req   = req[gnt_idx];
  assign w_tmo_hit   = (TIMEOUT != 0) && (r_cnt == CW'(c_tmo_last));
  assign w_tmo_rel   = w_tmo_hit && !w_lock;
  assign w_release   = done || !w_cur_req || w_tmo_rel;
  // tmo only flags a release that nothing of higher priority explains
  assign w_tmo_evt   = !done && w_cur_req && w_tmo_rel;
  assign w_hold_sat  = w_lock && w_tmo_hit;
  assign w_idle_pick = f_pick(req, r_ptr);
  assign w_next_pick = f_pick(req & ~(8'b1 << gnt_idx), gnt_idx + 3'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= c_idle;
      r_ptr   <= 3'd0;
      r_cnt   <= '0;
      gnt_idx <= 3'd0;
      gnt_vld <= 1'b0;
      tmo     <= 1'b0;
    end else begin
      tmo <= 1'b0;
      case (r_state)
        c_idle: begin
          if (w_idle_pick[3]) begin
            gnt_idx <= w_idle_pick[2:0];
            gnt_vld <= 1'b1;
            r_cnt   <= '0;
            r_state <= c_grant;
          end else begin
            gnt_vld <= 1'b0;
          end
        end
        default: begin
          if (w_release) begin
            r_ptr <= gnt_idx + 3'd1;
            tmo   <= w_tmo_evt;
            // Hand over in the same edge when someone else is waiting.
            if (w_next_pick[3]) begin
              gnt_idx <= w_next_pick[2:0];
              r_cnt   <= '0;
            end else begin
              gnt_vld <= 1'b0;
              r_state <= c_idle;
            end
          end else if (!w_hold_sat) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/rr_arb8_idx.md
Name: rr_arb8_idx

Overview:
- 8-requester round-robin arbiter that outputs the granted requester as a registered 3-bit binary index plus a valid flag.
- Sits directly upstream of the 3->8 decoder. The decoder turns gnt_idx into a one-hot grant vector; gnt_vld qualifies that vector.
- Owns fairness, grant hold/release handshake and a hold-timeout so no single requester starves the others.

Parameters:
- TIMEOUT, 16, max cycles a grant may be held before forced release; 0 disables timeout; legal range 0..255.
- CW, 8, width of the hold-cycle counter; must satisfy 2^CW > TIMEOUT.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- req  input  8  request vector, bit i = requester i; level-sensitive
- done  input  1  current grantee releases the grant this cycle
- gnt_idx  output  3  index of granted requester (binary, feeds decoder)
- gnt_vld  output  1  gnt_idx is a live grant
- tmo  output  1  one-cycle pulse: current grant was force-released by timeout

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, ptr=0, hold_cnt=0, gnt_idx=0, gnt_vld=0, tmo=0. A reset mid-grant drops the grant at that edge.
- ptr (3 bits) is the highest-priority index. Search order is ptr, ptr+1, ..., 7, 0, ..., ptr-1 (mod 8).
- State IDLE:
  - If req != 0: grant the first set bit in search order; gnt_idx<=winner, gnt_vld<=1, hold_cnt<=0, go to GRANT.
  - Latency from req rising to gnt_vld is 1 cycle.
  - If req == 0: stay in IDLE, gnt_vld=0.
- State GRANT:
  - gnt_idx is stable; hold_cnt increments each cycle.
  - Release condition, in priority order:
    - (a) done=1
    - (b) req[gnt_idx]=0 (requester withdrew)
    - (c) TIMEOUT!=0 and hold_cnt==TIMEOUT-1; also pulse tmo=1 for that cycle's next edge only.
  - On release: ptr<=gnt_idx+1 (7 wraps to 0).
  - Back-to-back grants: in the release cycle, arbitrate among req with gnt_idx masked out, searching from gnt_idx+1.
    - If another requester wins: next cycle gnt_vld stays 1 with the new gnt_idx and hold_cnt<=0 (no bubble).
    - If none wins: next state IDLE, gnt_vld<=0.
  - The released requester can win again only after passing through IDLE or after all others.
- done while in IDLE is ignored.
- done and timeout in the same cycle: treat as done; tmo stays 0.
- gnt_idx holds its last value while gnt_vld=0; downstream must qualify with gnt_vld.
- All outputs are registered; no combinational path from req or done to outputs.

Optional Feature:
- Macro: RR_ARB8_LOCK_EN.
- When defined:
  - Adds input port lock (1 bit), placed after done.
  - While in GRANT with lock=1, timeout release (c) is suppressed and hold_cnt saturates at TIMEOUT-1.
  - done and withdrawal still release.
  - Timeout re-arms the cycle lock falls: if hold_cnt is already TIMEOUT-1, the grant releases that cycle.
- When undefined: no lock port; behaviour exactly as above.

Test Plan:
- Reset/idle: hold rst_n=0 for 2 cycles with req=8'hFF -> gnt_vld=0, gnt_idx=0, tmo=0. Release reset with req=8'h00 -> gnt_vld stays 0.
- Rotation: req=8'hFF held, done pulsed each grant -> gnt_idx sequence 0,1,2,...,7,0 with no gnt_vld bubbles.
- Withdrawal and skip: req=8'b1000_0100 from ptr=0 -> grant 2. Drop req[2] -> next cycle grant 7. Drop req[7] -> next cycle gnt_vld=0 and ptr=0 (7 wrapped).
- Timeout: TIMEOUT=4, req=8'h01 only, no done -> grant 0 for 4 cycles, tmo pulses once, 1-cycle gap, then grant 0 again (sole requester). Repeat with req=8'h03 -> grants alternate 0,1.
- Simultaneous events: done=1 on the same cycle the timeout would fire -> tmo=0, next grantee selected normally. Mid-grant rst_n=0 -> gnt_vld=0 after that edge, next grant starts from ptr=0.
- Lock (RR_ARB8_LOCK_EN defined, TIMEOUT=4): lock=1 for 10 cycles -> no tmo, grant held. Drop lock -> release that cycle with a tmo pulse.
